// File: rtl/nios_descriptor_fetch.sv
// Avalon-MM descriptor chain walker: fetches 4-word descriptors, hands them to the DMA engine, writes back status.
// Optional completed-descriptor counter enabled by DESC_FETCH_STATS_EN.
module nios_descriptor_fetch #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned PTR_W     = 8,
    parameter int unsigned MAX_CHAIN = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PTR_W-1:0]  start_ptr,
    input  logic              abort,
    output logic              busy,
    output logic              irq,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_src,
    output logic [31:0]       desc_dst,
    output logic [23:0]       desc_len,
    input  logic              dma_done,
    output logic [15:0]       desc_count
);
    localparam int unsigned CNT_W = $clog2(MAX_CHAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CHECK, S_ISSUE, S_WAIT_DONE, S_WRITEBACK, S_NEXT, S_END
    } state_t;

    state_t             state, state_d;
    logic [2:0]         fcnt, fcnt_d;
    logic [PTR_W-1:0]   ptr, ptr_d;
    logic [CNT_W-1:0]   chain_cnt, chain_d;
    logic               abort_pend, abort_d;
    logic [1:0]         err_d;
    logic [31:0]        ctrl;
    logic               valid_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               cs_d, we_d;
    logic [3:0]         be_d;
    logic [31:0]        wd_d;
    logic               abort_any;
    logic               unused_ctrl;

    assign abort_any   = abort | abort_pend;
    assign unused_ctrl = ^ctrl[30:24];

    // Next-state and next-output logic; memory strobes are computed one cycle ahead of the bus.
    always_comb begin
        state_d = state;
        fcnt_d  = fcnt;
        ptr_d   = ptr;
        chain_d = chain_cnt;
        err_d   = err_code;
        abort_d = abort_pend | (abort && (state != S_IDLE));
        valid_d = 1'b0;
        addr_d  = mem_address;
        cs_d    = 1'b0;
        we_d    = 1'b0;
        be_d    = 4'b0000;
        wd_d    = 32'h0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = start_ptr;
                    chain_d = '0;
                    err_d   = 2'd0;
                    abort_d = 1'b0;
                    fcnt_d  = 3'd0;
                    addr_d  = {start_ptr, 2'b00};
                    cs_d    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort_any) begin
                    err_d   = 2'd3;
                    state_d = S_END;
                end else if (fcnt == 3'd4) begin
                    fcnt_d  = 3'd0;
                    state_d = S_CHECK;
                end else begin
                    fcnt_d = fcnt + 3'd1;
                    if (fcnt < 3'd3) begin
                        cs_d   = 1'b1;
                        addr_d = {ptr, 2'(fcnt + 3'd1)};
                    end
                end
            end
            S_CHECK: begin
                if (!ctrl[31]) begin
                    err_d   = 2'd1;
                    state_d = S_END;
                end else if (chain_cnt == CNT_W'(MAX_CHAIN)) begin
                    err_d   = 2'd2;
                    state_d = S_END;
                end else if (abort_any) begin
                    err_d   = 2'd3;
                    state_d = S_END;
                end else begin
                    valid_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A handshake in the same cycle as abort wins; the abort is then honoured after writeback.
                if (desc_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (abort_any) begin
                    err_d   = 2'd3;
                    state_d = S_END;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (dma_done) begin
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    be_d    = 4'b1000;
                    wd_d    = {8'h40, ctrl[23:0]};
                    addr_d  = {ptr, 2'd3};
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                chain_d = chain_cnt + CNT_W'(1);
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (abort_any) begin
                    err_d   = 2'd3;
                    state_d = S_END;
                end else if (ctrl[8]) begin
                    state_d = S_END;
                end else begin
                    ptr_d   = PTR_W'(ctrl[7:0]);
                    fcnt_d  = 3'd0;
                    addr_d  = {PTR_W'(ctrl[7:0]), 2'b00};
                    cs_d    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_END: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            fcnt           <= 3'd0;
            ptr            <= '0;
            chain_cnt      <= '0;
            abort_pend     <= 1'b0;
            err_code       <= 2'd0;
            ctrl           <= 32'h0;
            desc_src       <= 32'h0;
            desc_dst       <= 32'h0;
            desc_len       <= 24'h0;
            desc_valid     <= 1'b0;
            busy           <= 1'b0;
            irq            <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= 4'b0000;
            mem_writedata  <= 32'h0;
        end else begin
            state          <= state_d;
            fcnt           <= fcnt_d;
            ptr            <= ptr_d;
            chain_cnt      <= chain_d;
            abort_pend     <= abort_d;
            err_code       <= err_d;
            desc_valid     <= valid_d;
            busy           <= (state_d != S_IDLE);
            irq            <= (state_d == S_END);
            mem_address    <= addr_d;
            mem_chipselect <= cs_d;
            mem_write      <= we_d;
            mem_byteenable <= be_d;
            mem_writedata  <= wd_d;
            // Read data for word k-1 is on the bus during fetch step k.
            if (state == S_FETCH) begin
                case (fcnt)
                    3'd1:    desc_src <= mem_readdata;
                    3'd2:    desc_dst <= mem_readdata;
                    3'd3:    desc_len <= mem_readdata[23:0];
                    3'd4:    ctrl     <= mem_readdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef DESC_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            desc_count <= 16'h0;
        end else if (state == S_WRITEBACK && desc_count != 16'hFFFF) begin
            desc_count <= desc_count + 16'd1;
        end
    end
`else
    assign desc_count = 16'h0;
`endif

endmodule

// File: tb/tb_nios_descriptor_fetch.sv
// Directed bench for nios_descriptor_fetch with a 1-cycle-latency descriptor RAM and a simple DMA model.
module tb_nios_descriptor_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_ptr = 8'd0;
    logic        abort = 1'b0;
    logic        busy, irq;
    logic [1:0]  err_code;
    logic [9:0]  mem_address;
    logic        mem_chipselect, mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        desc_valid;
    logic        desc_ready = 1'b0;
    logic [31:0] desc_src, desc_dst;
    logic [23:0] desc_len;
    logic        dma_done = 1'b0;
    logic [15:0] desc_count;

    always #5 clk = ~clk;

    nios_descriptor_fetch #(.ADDR_W(10), .PTR_W(8), .MAX_CHAIN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .start_ptr(start_ptr), .abort(abort),
        .busy(busy), .irq(irq), .err_code(err_code),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_src(desc_src), .desc_dst(desc_dst),
        .desc_len(desc_len), .dma_done(dma_done), .desc_count(desc_count)
    );

    // Descriptor RAM with a bench load port; relock models the DMA re-arming own after writeback.
    logic [31:0] mem [0:1023];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_addr = 10'd0;
    logic [31:0] tb_data = 32'h0;
    logic        relock = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end else if (mem_chipselect && mem_write) begin
            mem[mem_address] <= merge(mem[mem_address], mem_writedata, mem_byteenable) |
                                (relock ? 32'h8000_0000 : 32'h0);
        end else if (mem_chipselect) begin
            mem_readdata <= mem[mem_address];
        end
    end

    // Bus monitor: counts handshakes, writes and irq pulses, logs handed-off descriptors.
    logic        clr = 1'b0;
    int          hs_cnt = 0, wr_cnt = 0, irq_cnt = 0, valid_cnt = 0;
    logic [31:0] hs_src [0:7];
    logic [31:0] hs_dst [0:7];
    logic [23:0] hs_len [0:7];

    always @(posedge clk) begin
        if (clr) begin
            hs_cnt <= 0; wr_cnt <= 0; irq_cnt <= 0; valid_cnt <= 0;
        end else begin
            if (desc_valid) valid_cnt <= valid_cnt + 1;
            if (desc_valid && desc_ready) begin
                if (hs_cnt < 8) begin
                    hs_src[hs_cnt] <= desc_src;
                    hs_dst[hs_cnt] <= desc_dst;
                    hs_len[hs_cnt] <= desc_len;
                end
                hs_cnt <= hs_cnt + 1;
            end
            if (mem_chipselect && mem_write) wr_cnt <= wr_cnt + 1;
            if (irq) irq_cnt <= irq_cnt + 1;
        end
    end

    int n_checks = 0, n_errors = 0;
    int exp_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_of(input logic [7:0] p); return 32'h1000 + (32'(p) << 8); endfunction
    function automatic logic [31:0] dst_of(input logic [7:0] p); return 32'h2000 + (32'(p) << 8); endfunction
    function automatic logic [31:0] len_of(input logic [7:0] p); return 32'd64 + 32'(p); endfunction

    function automatic logic [31:0] dc_exp();
`ifdef DESC_FETCH_STATS_EN
        return 32'(exp_total);
`else
        return 32'h0;
`endif
    endfunction

    task automatic mem_load(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic load_desc(input logic [7:0] p, input logic [31:0] ctl);
        mem_load({p, 2'd0}, src_of(p));
        mem_load({p, 2'd1}, dst_of(p));
        mem_load({p, 2'd2}, len_of(p));
        mem_load({p, 2'd3}, ctl);
    endtask

    task automatic do_start(input logic [7:0] p);
        @(negedge clk);
        start = 1'b1; start_ptr = p; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int g = 0;
        while (!desc_valid && g < 200) begin @(negedge clk); g++; end
        if (!desc_valid) begin n_checks++; n_errors++; $display("FAIL %s: desc_valid timeout", name); end
    endtask

    task automatic wait_irq(input string name);
        int g = 0;
        while (irq_cnt == 0 && g < 200) begin @(negedge clk); g++; end
        if (irq_cnt == 0) begin n_checks++; n_errors++; $display("FAIL %s: irq timeout", name); end
    endtask

    // DMA model: accept each descriptor after dly cycles, then report completion.
    task automatic run_chain(input int dly);
        int g = 0;
        while (irq_cnt == 0 && g < 2000) begin
            @(negedge clk); g++;
            if (desc_valid) begin
                repeat (dly) @(negedge clk);
                desc_ready = 1'b1;
                @(negedge clk);
                desc_ready = 1'b0;
                repeat (3) @(negedge clk);
                dma_done = 1'b1;
                @(negedge clk);
                dma_done = 1'b0;
            end
        end
        if (irq_cnt == 0) begin n_checks++; n_errors++; $display("FAIL chain: irq timeout"); end
    endtask

    typedef struct {
        logic [7:0]  ptr;
        int          dly;
        logic        relock;
        int          exp_hs;
        int          exp_wr;
        logic [1:0]  exp_err;
        logic [23:0] seq;
        logic [9:0]  chk_a;
        logic [31:0] chk_d;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'd0, 0, 1'b0, 1, 1, 2'd0, {8'd0, 8'd0, 8'd0}, 10'd3,  32'h4000_0100};
        vecs[1] = '{8'd2, 3, 1'b0, 3, 3, 2'd0, {8'd9, 8'd5, 8'd2}, 10'd39, 32'h4000_0100};
        vecs[2] = '{8'd4, 0, 1'b0, 0, 0, 2'd1, {8'd0, 8'd0, 8'd0}, 10'd19, 32'h0000_0100};
        vecs[3] = '{8'd7, 1, 1'b1, 4, 4, 2'd2, {8'd7, 8'd7, 8'd7}, 10'd31, 32'hC000_0007};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_valid", 32'(desc_valid), 32'h0);
        check("rst_cs", 32'(mem_chipselect), 32'h0);
        check("rst_err", 32'(err_code), 32'h0);
        check("rst_count", 32'(desc_count), 32'h0);

        load_desc(8'd0, 32'h8000_0100);
        load_desc(8'd2, 32'h8000_0005);
        load_desc(8'd5, 32'h8000_0009);
        load_desc(8'd9, 32'h8000_0100);
        load_desc(8'd4, 32'h0000_0100);
        load_desc(8'd7, 32'h8000_0007);

        for (int i = 0; i < 4; i++) begin
            relock = vecs[i].relock;
            do_start(vecs[i].ptr);
            run_chain(vecs[i].dly);
            relock = 1'b0;
            exp_total += vecs[i].exp_wr;
            check($sformatf("v%0d_hs", i), 32'(hs_cnt), 32'(vecs[i].exp_hs));
            check($sformatf("v%0d_wr", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_err", i), 32'(err_code), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_irq", i), 32'(irq_cnt), 32'h1);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h0);
            check($sformatf("v%0d_mem", i), mem[vecs[i].chk_a], vecs[i].chk_d);
            check($sformatf("v%0d_count", i), 32'(desc_count), dc_exp());
            if (vecs[i].exp_hs == 0)
                check($sformatf("v%0d_novalid", i), 32'(valid_cnt), 32'h0);
            for (int k = 0; k < 3 && k < vecs[i].exp_hs; k++)
                check($sformatf("v%0d_src%0d", i, k), hs_src[k], src_of(vecs[i].seq[8*k +: 8]));
            if (vecs[i].exp_hs > 0) begin
                check($sformatf("v%0d_dst", i), hs_dst[0], dst_of(vecs[i].seq[7:0]));
                check($sformatf("v%0d_len", i), 32'(hs_len[0]), len_of(vecs[i].seq[7:0]));
            end
        end
        check("chain_wb5", mem[23], 32'h4000_0009);

        // Abort while fetching: no write, err 3.
        mem_load(10'd3, 32'h8000_0100);
        do_start(8'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_irq("abf");
        check("abf_err", 32'(err_code), 32'h3);
        check("abf_wr", 32'(wr_cnt), 32'h0);
        check("abf_hs", 32'(hs_cnt), 32'h0);
        check("abf_mem", mem[3], 32'h8000_0100);

        // Abort while waiting for completion, plus an ignored start while busy.
        do_start(8'd0);
        wait_valid("abw");
        desc_ready = 1'b1;
        @(negedge clk);
        desc_ready = 1'b0;
        abort = 1'b1; start = 1'b1; start_ptr = 8'd5;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        wait_irq("abw");
        exp_total += 1;
        check("abw_err", 32'(err_code), 32'h3);
        check("abw_wr", 32'(wr_cnt), 32'h1);
        check("abw_hs", 32'(hs_cnt), 32'h1);
        check("abw_mem", mem[3], 32'h4000_0100);
        check("abw_count", 32'(desc_count), dc_exp());

        // Reset during WAIT_DONE, then a clean restart.
        mem_load(10'd3, 32'h8000_0100);
        do_start(8'd0);
        wait_valid("rst");
        desc_ready = 1'b1;
        @(negedge clk);
        desc_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rmid_busy", 32'(busy), 32'h0);
        check("rmid_valid", 32'(desc_valid), 32'h0);
        reset = 1'b0;
        exp_total = 0;
        dma_done = 1'b1;
        @(negedge clk);
        dma_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rmid_wr", 32'(wr_cnt), 32'h0);
        check("rmid_mem", mem[3], 32'h8000_0100);
        check("rmid_count", 32'(desc_count), dc_exp());
        do_start(8'd0);
        run_chain(0);
        exp_total += 1;
        check("rre_hs", 32'(hs_cnt), 32'h1);
        check("rre_err", 32'(err_code), 32'h0);
        check("rre_mem", mem[3], 32'h4000_0100);
        check("rre_count", 32'(desc_count), dc_exp());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
